// File: rtl/alu_cmd_issuer_pkg.sv
// Shared definitions for the ALU command issuer: opcode encodings, default width, FSM states.
// Used by alu_cmd_issuer (optional feature macro: ALU_ISSUE_ZERO_FLAG_EN).
package alu_cmd_issuer_pkg;

   localparam int ALU_DATA_W = 8;

   localparam logic [1:0] ALU_OP_ADD = 2'd0;
   localparam logic [1:0] ALU_OP_SUB = 2'd1;
   localparam logic [1:0] ALU_OP_AND = 2'd2;
   localparam logic [1:0] ALU_OP_OR  = 2'd3;

   typedef enum logic [1:0] {
      S_IDLE = 2'd0,
      S_EXEC = 2'd1,
      S_CAPT = 2'd2,
      S_HOLD = 2'd3
   } issue_state_t;

endpackage

// File: rtl/alu_cmd_fifo.sv
// Small command FIFO with a combinational head view so the issuer can load and pop on the same edge.
// Asynchronous active-low reset clears pointers and count; storage is not reset.
module alu_cmd_fifo #(
   parameter int WIDTH = 18,
   parameter int DEPTH = 4
) (
   input  logic             clk,
   input  logic             rst_n,
   input  logic             push,
   input  logic [WIDTH-1:0] wdata,
   input  logic             pop,
   output logic [WIDTH-1:0] rdata,
   output logic             full,
   output logic             empty
);

   localparam int AW = $clog2(DEPTH);

   logic [WIDTH-1:0] r_mem [DEPTH];
   logic [AW-1:0]    r_wr_ptr;
   logic [AW-1:0]    r_rd_ptr;
   logic [AW:0]      r_count;
   logic             w_do_push;
   logic             w_do_pop;

   assign full      = (r_count == (AW+1)'(DEPTH));
   assign empty     = (r_count == '0);
   assign w_do_push = push && !full;
   assign w_do_pop  = pop && !empty;
   assign rdata     = r_mem[r_rd_ptr];

   always_ff @(posedge clk) begin
      if (w_do_push) begin
         r_mem[r_wr_ptr] <= wdata;
      end
   end

   // Pointers are exactly log2(DEPTH) bits, so they wrap without compare logic.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         r_wr_ptr <= '0;
         r_rd_ptr <= '0;
         r_count  <= '0;
      end else begin
         if (w_do_push) begin
            r_wr_ptr <= r_wr_ptr + 1'b1;
         end
         if (w_do_pop) begin
            r_rd_ptr <= r_rd_ptr + 1'b1;
         end
         case ({w_do_push, w_do_pop})
            2'b10:   r_count <= r_count + 1'b1;
            2'b01:   r_count <= r_count - 1'b1;
            default: r_count <= r_count;
         endcase
      end
   end

endmodule

// File: rtl/alu_cmd_issuer.sv
// Buffers ALU commands, issues them one at a time to a 1-cycle registered ALU and returns results in order.
// Optional: define ALU_ISSUE_ZERO_FLAG_EN to add the res_zero output.
module alu_cmd_issuer
   import alu_cmd_issuer_pkg::*;
#(
   parameter int DATA_W = ALU_DATA_W,
   parameter int DEPTH  = 4
) (
   input  logic              clk,
   input  logic              rst_n,
   input  logic              cmd_valid,
   output logic              cmd_ready,
   input  logic [DATA_W-1:0] cmd_a,
   input  logic [DATA_W-1:0] cmd_b,
   input  logic [1:0]        cmd_op,
   output logic [DATA_W-1:0] alu_a,
   output logic [DATA_W-1:0] alu_b,
   output logic [1:0]        alu_op,
   input  logic [DATA_W-1:0] alu_c,
   output logic              res_valid,
   input  logic              res_ready,
   output logic [DATA_W-1:0] res_data,
   output logic [1:0]        res_op,
   output logic              busy
`ifdef ALU_ISSUE_ZERO_FLAG_EN
   ,
   output logic              res_zero
`endif
);

   localparam int CMD_W = 2*DATA_W + 2;

   issue_state_t      r_state;
   logic [DATA_W-1:0] r_alu_a;
   logic [DATA_W-1:0] r_alu_b;
   logic [1:0]        r_alu_op;
   logic              r_res_valid;
   logic [DATA_W-1:0] r_res_data;
   logic [1:0]        r_res_op;
   logic [CMD_W-1:0]  w_head;
   logic              w_full;
   logic              w_empty;
   logic              w_push;
   logic              w_pop;

   assign cmd_ready = !w_full;
   assign w_push    = cmd_valid && !w_full;
   // The head is consumed exactly on the edges where the FSM loads the ALU operands.
   assign w_pop     = !w_empty && ((r_state == S_IDLE) || ((r_state == S_HOLD) && res_ready));

   alu_cmd_fifo #(
      .WIDTH (CMD_W),
      .DEPTH (DEPTH)
   ) u_fifo (
      .clk   (clk),
      .rst_n (rst_n),
      .push  (w_push),
      .wdata ({cmd_op, cmd_a, cmd_b}),
      .pop   (w_pop),
      .rdata (w_head),
      .full  (w_full),
      .empty (w_empty)
   );

`ifdef ALU_ISSUE_ZERO_FLAG_EN
   logic r_res_zero;
   assign res_zero = r_res_zero;

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         r_res_zero <= 1'b0;
      end else if (r_state == S_CAPT) begin
         r_res_zero <= (alu_c == '0);
      end
   end
`endif

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         r_state     <= S_IDLE;
         r_alu_a     <= '0;
         r_alu_b     <= '0;
         r_alu_op    <= '0;
         r_res_valid <= 1'b0;
         r_res_data  <= '0;
         r_res_op    <= '0;
      end else begin
         case (r_state)
            S_IDLE: begin
               if (!w_empty) begin
                  {r_alu_op, r_alu_a, r_alu_b} <= w_head;
                  r_state <= S_EXEC;
               end
            end
            S_EXEC: begin
               r_state <= S_CAPT;
            end
            S_CAPT: begin
               r_res_data  <= alu_c;
               r_res_op    <= r_alu_op;
               r_res_valid <= 1'b1;
               r_state     <= S_HOLD;
            end
            S_HOLD: begin
               if (res_ready) begin
                  r_res_valid <= 1'b0;
                  if (!w_empty) begin
                     {r_alu_op, r_alu_a, r_alu_b} <= w_head;
                     r_state <= S_EXEC;
                  end else begin
                     r_state <= S_IDLE;
                  end
               end
            end
            default: r_state <= S_IDLE;
         endcase
      end
   end

   assign alu_a     = r_alu_a;
   assign alu_b     = r_alu_b;
   assign alu_op    = r_alu_op;
   assign res_valid = r_res_valid;
   assign res_data  = r_res_data;
   assign res_op    = r_res_op;
   assign busy      = (r_state != S_IDLE) || !w_empty;

endmodule

// File: tb/tb_alu_cmd_issuer.sv
// Directed bench for alu_cmd_issuer driving a behavioural 8-bit registered ALU.
// Define ALU_ISSUE_ZERO_FLAG_EN to also exercise res_zero.
module tb_alu_cmd_issuer;
   import alu_cmd_issuer_pkg::*;

   logic       clk = 1'b0;
   logic       rst_n;
   logic       cmd_valid;
   logic       cmd_ready;
   logic [7:0] cmd_a;
   logic [7:0] cmd_b;
   logic [1:0] cmd_op;
   logic [7:0] alu_a;
   logic [7:0] alu_b;
   logic [1:0] alu_op;
   logic [7:0] alu_c;
   logic       res_valid;
   logic       res_ready;
   logic [7:0] res_data;
   logic [1:0] res_op;
   logic       busy;
`ifdef ALU_ISSUE_ZERO_FLAG_EN
   logic       res_zero;
`endif

   int n_checks = 0;
   int n_pass   = 0;

   always #3 clk = ~clk;

   alu_cmd_issuer #(.DATA_W(8), .DEPTH(4)) dut (
      .clk       (clk),
      .rst_n     (rst_n),
      .cmd_valid (cmd_valid),
      .cmd_ready (cmd_ready),
      .cmd_a     (cmd_a),
      .cmd_b     (cmd_b),
      .cmd_op    (cmd_op),
      .alu_a     (alu_a),
      .alu_b     (alu_b),
      .alu_op    (alu_op),
      .alu_c     (alu_c),
      .res_valid (res_valid),
      .res_ready (res_ready),
      .res_data  (res_data),
      .res_op    (res_op),
      .busy      (busy)
`ifdef ALU_ISSUE_ZERO_FLAG_EN
      ,
      .res_zero  (res_zero)
`endif
   );

   // Behavioural ALU: operands sampled on posedge, result registered.
   always_ff @(posedge clk) begin
      case (alu_op)
         ALU_OP_ADD: alu_c <= alu_a + alu_b;
         ALU_OP_SUB: alu_c <= alu_a - alu_b;
         ALU_OP_AND: alu_c <= alu_a & alu_b;
         default:    alu_c <= alu_a | alu_b;
      endcase
   end

   task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
      n_checks++;
      if (got === exp) begin
         n_pass++;
      end else begin
         $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
      end
   endtask

   task automatic step();
      @(posedge clk);
      #1;
   endtask

   task automatic push_cmd(input logic [7:0] a, input logic [7:0] b, input logic [1:0] op);
      int k;
      cmd_a     = a;
      cmd_b     = b;
      cmd_op    = op;
      cmd_valid = 1'b1;
      k = 0;
      while (!cmd_ready && k < 20) begin
         step();
         k++;
      end
      chk("push_ready", 32'(cmd_ready), 32'd1);
      step();
      cmd_valid = 1'b0;
   endtask

   task automatic collect(input string tag, input logic [7:0] ed, input logic [1:0] eo);
      int k;
      k = 0;
      while (!res_valid && k < 30) begin
         step();
         k++;
      end
      chk({tag, "_valid"}, 32'(res_valid), 32'd1);
      chk({tag, "_data"}, 32'(res_data), 32'(ed));
      chk({tag, "_op"}, 32'(res_op), 32'(eo));
      $display("result %s: data=0x%02h op=%0d", tag, res_data, res_op);
      step();
   endtask

   task automatic chk_reset_state(input string tag);
      chk({tag, "_res_valid"}, 32'(res_valid), 32'd0);
      chk({tag, "_cmd_ready"}, 32'(cmd_ready), 32'd1);
      chk({tag, "_busy"}, 32'(busy), 32'd0);
      chk({tag, "_alu_a"}, 32'(alu_a), 32'd0);
      chk({tag, "_alu_b"}, 32'(alu_b), 32'd0);
      chk({tag, "_alu_op"}, 32'(alu_op), 32'd0);
      chk({tag, "_res_data"}, 32'(res_data), 32'd0);
      chk({tag, "_res_op"}, 32'(res_op), 32'd0);
   endtask

   initial begin
      #200000;
      $display("FAIL watchdog: got timeout expected finish");
      $fatal(1, "watchdog");
   end

   initial begin
      int hits;
      rst_n     = 1'b0;
      cmd_valid = 1'b0;
      cmd_a     = '0;
      cmd_b     = '0;
      cmd_op    = '0;
      res_ready = 1'b0;

      // Reset values, then release with no command.
      step();
      step();
      chk_reset_state("rst");
      rst_n = 1'b1;
      step();
      step();
      chk_reset_state("rel");

      // Single ADD 7+3, result three edges after acceptance.
      cmd_a = 8'd7; cmd_b = 8'd3; cmd_op = ALU_OP_ADD;
      cmd_valid = 1'b1;
      res_ready = 1'b1;
      step();
      cmd_valid = 1'b0;
      chk("add_t0_valid", 32'(res_valid), 32'd0);
      chk("add_t0_busy", 32'(busy), 32'd1);
      step();
      chk("add_t1_alu_a", 32'(alu_a), 32'd7);
      chk("add_t1_alu_b", 32'(alu_b), 32'd3);
      chk("add_t1_alu_op", 32'(alu_op), 32'(ALU_OP_ADD));
      step();
      chk("add_t2_valid", 32'(res_valid), 32'd0);
      step();
      chk("add_t3_valid", 32'(res_valid), 32'd1);
      chk("add_t3_data", 32'(res_data), 32'd10);
      chk("add_t3_op", 32'(res_op), 32'(ALU_OP_ADD));
      $display("result add_single: data=0x%02h op=%0d", res_data, res_op);
      step();
      chk("add_t4_valid", 32'(res_valid), 32'd0);

      // Back-to-back commands, delivered in issue order.
      res_ready = 1'b0;
      push_cmd(8'd3, 8'd7, ALU_OP_SUB);
      push_cmd(8'hF0, 8'h3C, ALU_OP_AND);
      push_cmd(8'hF0, 8'h0F, ALU_OP_OR);
      push_cmd(8'h7F, 8'h01, ALU_OP_ADD);
      res_ready = 1'b1;
      collect("b2b_sub", 8'hFC, ALU_OP_SUB);
      collect("b2b_and", 8'h30, ALU_OP_AND);
      collect("b2b_or", 8'hFF, ALU_OP_OR);
      collect("b2b_add", 8'h80, ALU_OP_ADD);

      // Back-pressure: one command in the ALU plus DEPTH buffered, then full.
      res_ready = 1'b0;
      push_cmd(8'd1, 8'd2, ALU_OP_ADD);
      push_cmd(8'd9, 8'd4, ALU_OP_SUB);
      push_cmd(8'h80, 8'h80, ALU_OP_ADD);
      push_cmd(8'hAA, 8'h0F, ALU_OP_AND);
      push_cmd(8'h50, 8'h05, ALU_OP_OR);
      chk("bp_full_ready", 32'(cmd_ready), 32'd0);
      cmd_a = 8'h11; cmd_b = 8'h22; cmd_op = ALU_OP_OR;
      cmd_valid = 1'b1;
      for (int i = 0; i < 3; i++) begin
         step();
         chk("bp_stall_valid", 32'(res_valid), 32'd1);
         chk("bp_stall_data", 32'(res_data), 32'd3);
         chk("bp_stall_ready", 32'(cmd_ready), 32'd0);
      end
      cmd_valid = 1'b0;
      res_ready = 1'b1;
      collect("bp_add", 8'h03, ALU_OP_ADD);
      collect("bp_sub", 8'h05, ALU_OP_SUB);
      collect("bp_wrap", 8'h00, ALU_OP_ADD);
      collect("bp_and", 8'h0A, ALU_OP_AND);
      collect("bp_or", 8'h55, ALU_OP_OR);
      step();
      step();
      chk("bp_drained_busy", 32'(busy), 32'd0);
      chk("bp_drained_ready", 32'(cmd_ready), 32'd1);

`ifdef ALU_ISSUE_ZERO_FLAG_EN
      res_ready = 1'b0;
      push_cmd(8'd5, 8'd5, ALU_OP_SUB);
      push_cmd(8'd1, 8'd1, ALU_OP_ADD);
      res_ready = 1'b1;
      hits = 0;
      while (!res_valid && hits < 30) begin
         step();
         hits++;
      end
      chk("zf_sub_data", 32'(res_data), 32'd0);
      chk("zf_sub_zero", 32'(res_zero), 32'd1);
      step();
      hits = 0;
      while (!res_valid && hits < 30) begin
         step();
         hits++;
      end
      chk("zf_add_data", 32'(res_data), 32'd2);
      chk("zf_add_zero", 32'(res_zero), 32'd0);
      step();
`endif

      // Reset while in S_CAPT with two commands still queued.
      res_ready = 1'b1;
      push_cmd(8'h21, 8'h12, ALU_OP_ADD);
      push_cmd(8'h33, 8'h11, ALU_OP_SUB);
      push_cmd(8'h44, 8'h0F, ALU_OP_OR);
      chk("mid_busy", 32'(busy), 32'd1);
      chk("mid_alu_a", 32'(alu_a), 32'h21);
      #1;
      rst_n = 1'b0;
      #1;
      chk_reset_state("mid_rst");
`ifdef ALU_ISSUE_ZERO_FLAG_EN
      chk("mid_rst_zero", 32'(res_zero), 32'd0);
`endif
      @(negedge clk);
      rst_n = 1'b1;
      hits = 0;
      for (int i = 0; i < 12; i++) begin
         step();
         if (res_valid) hits++;
      end
      chk("mid_no_result", 32'(hits), 32'd0);
      chk("mid_after_busy", 32'(busy), 32'd0);

      $display("%0d/%0d checks passed", n_pass, n_checks);
      $finish;
   end

endmodule
